// File: rtl/commit_queue.sv
// commit_queue: parametrised in-order commit buffer between issue and commit.
//   Issue allocates the tail entry in program order and hands out its index as
//   the transaction ID. Functional units write results back out of order by ID.
//   The head entry retires through a valid/ack handshake once its result is in.
//   A flush discards every entry and rewinds both pointers.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               discard all entries
//   issue_*               allocation request/ready, PC, rd, ID of next allocation
//   wb_*                  packed per-port write-back strobes, IDs, results, exceptions
//   commit_*              head entry contents, valid/ack handshake
//   count_o, empty_o, full_o  occupancy
module commit_queue #(
  parameter int unsigned NR_ENTRIES  = 4,
  parameter int unsigned NR_WB_PORTS = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  output logic                                   issue_ready_o,
  input  logic [63:0]                            issue_pc_i,
  input  logic [4:0]                             issue_rd_i,
  output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS*DATA_WIDTH-1:0]      wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_valid_i,
  input  logic [NR_WB_PORTS*64-1:0]              wb_ex_cause_i,
  output logic                                   commit_valid_o,
  input  logic                                   commit_ack_i,
  output logic [TRANS_ID_BITS-1:0]               commit_trans_id_o,
  output logic [63:0]                            commit_pc_o,
  output logic [4:0]                             commit_rd_o,
  output logic [DATA_WIDTH-1:0]                  commit_result_o,
  output logic                                   commit_ex_valid_o,
  output logic [63:0]                            commit_ex_cause_o,
  output logic [TRANS_ID_BITS:0]                 count_o,
  output logic                                   empty_o,
  output logic                                   full_o
);

  logic [NR_ENTRIES-1:0] alloc_q, alloc_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;
  logic [NR_ENTRIES-1:0] ex_valid_q, ex_valid_d;
  logic [63:0]           pc_q [NR_ENTRIES];
  logic [63:0]           pc_d [NR_ENTRIES];
  logic [4:0]            rd_q [NR_ENTRIES];
  logic [4:0]            rd_d [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] result_q [NR_ENTRIES];
  logic [DATA_WIDTH-1:0] result_d [NR_ENTRIES];
  logic [63:0]           ex_cause_q [NR_ENTRIES];
  logic [63:0]           ex_cause_d [NR_ENTRIES];

  logic [TRANS_ID_BITS-1:0] head_q, head_d;
  logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
  logic [TRANS_ID_BITS:0]   count_q, count_d;

  logic                     issue_fire;
  logic                     commit_fire;
  logic [TRANS_ID_BITS-1:0] wb_id [NR_WB_PORTS];

  assign full_o        = (count_q == (TRANS_ID_BITS+1)'(NR_ENTRIES));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign issue_ready_o = ~full_o;
  assign issue_trans_id_o = tail_q;
  assign issue_fire    = issue_valid_i & issue_ready_o;

  assign commit_valid_o    = alloc_q[head_q] & done_q[head_q];
  assign commit_fire       = commit_valid_o & commit_ack_i;
  assign commit_trans_id_o = head_q;
  assign commit_pc_o       = pc_q[head_q];
  assign commit_rd_o       = rd_q[head_q];
  assign commit_result_o   = result_q[head_q];
  assign commit_ex_valid_o = ex_valid_q[head_q];
  assign commit_ex_cause_o = ex_cause_q[head_q];

  always_comb begin
    for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
      wb_id[p] = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
    end
  end

  always_comb begin
    alloc_d    = alloc_q;
    done_d     = done_q;
    ex_valid_d = ex_valid_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    result_d   = result_q;
    ex_cause_d = ex_cause_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    // Tail slot is never allocated when issue fires, so it cannot collide with a write-back.
    if (issue_fire) begin
      alloc_d[tail_q]    = 1'b1;
      done_d[tail_q]     = 1'b0;
      pc_d[tail_q]       = issue_pc_i;
      rd_d[tail_q]       = issue_rd_i;
      result_d[tail_q]   = '0;
      ex_valid_d[tail_q] = 1'b0;
      ex_cause_d[tail_q] = '0;
      tail_d             = tail_q + TRANS_ID_BITS'(1);
    end

    // Highest port first so the lowest-numbered port lands last and wins a tie.
    for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
      if (wb_valid_i[p] && alloc_q[wb_id[p]]) begin
        done_d[wb_id[p]]     = 1'b1;
        result_d[wb_id[p]]   = wb_result_i[p*DATA_WIDTH +: DATA_WIDTH];
        ex_valid_d[wb_id[p]] = wb_ex_valid_i[p];
        ex_cause_d[wb_id[p]] = wb_ex_cause_i[p*64 +: 64];
      end
    end

    if (commit_fire) begin
      alloc_d[head_q]    = 1'b0;
      done_d[head_q]     = 1'b0;
      pc_d[head_q]       = '0;
      rd_d[head_q]       = '0;
      result_d[head_q]   = '0;
      ex_valid_d[head_q] = 1'b0;
      ex_cause_d[head_q] = '0;
      head_d             = head_q + TRANS_ID_BITS'(1);
    end

    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + (TRANS_ID_BITS+1)'(1);
      2'b01:   count_d = count_q - (TRANS_ID_BITS+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      alloc_d    = '0;
      done_d     = '0;
      ex_valid_d = '0;
      for (int e = 0; e < int'(NR_ENTRIES); e++) begin
        pc_d[e]       = '0;
        rd_d[e]       = '0;
        result_d[e]   = '0;
        ex_cause_d[e] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q    <= '0;
      done_q     <= '0;
      ex_valid_q <= '0;
      for (int e = 0; e < int'(NR_ENTRIES); e++) begin
        pc_q[e]       <= '0;
        rd_q[e]       <= '0;
        result_q[e]   <= '0;
        ex_cause_q[e] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      alloc_q    <= alloc_d;
      done_q     <= done_d;
      ex_valid_q <= ex_valid_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      ex_cause_q <= ex_cause_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_commit_queue.sv
// Directed self-checking bench for commit_queue (4 entries, 4 write-back ports).
module tb_commit_queue;
  localparam int NE = 4;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int TB = 2;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          issue_valid, issue_ready;
  logic [63:0]   issue_pc;
  logic [4:0]    issue_rd;
  logic [TB-1:0] issue_trans_id;
  logic [NP-1:0]    wb_valid, wb_ex_valid;
  logic [NP*TB-1:0] wb_trans_id;
  logic [NP*DW-1:0] wb_result;
  logic [NP*64-1:0] wb_ex_cause;
  logic          commit_valid, commit_ack;
  logic [TB-1:0] commit_trans_id;
  logic [63:0]   commit_pc;
  logic [4:0]    commit_rd;
  logic [DW-1:0] commit_result;
  logic          commit_ex_valid;
  logic [63:0]   commit_ex_cause;
  logic [TB:0]   count;
  logic          empty, full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  commit_queue #(.NR_ENTRIES(NE), .NR_WB_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_pc_i(issue_pc), .issue_rd_i(issue_rd), .issue_trans_id_o(issue_trans_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
    .wb_ex_valid_i(wb_ex_valid), .wb_ex_cause_i(wb_ex_cause),
    .commit_valid_o(commit_valid), .commit_ack_i(commit_ack),
    .commit_trans_id_o(commit_trans_id), .commit_pc_o(commit_pc), .commit_rd_o(commit_rd),
    .commit_result_o(commit_result), .commit_ex_valid_o(commit_ex_valid),
    .commit_ex_cause_o(commit_ex_cause),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; issue_valid = 1'b0; issue_pc = '0; issue_rd = '0;
    wb_valid = '0; wb_trans_id = '0; wb_result = '0; wb_ex_valid = '0; wb_ex_cause = '0;
    commit_ack = 1'b0;
  endtask

  // Advance past the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
    #1;
  endtask

  task automatic set_wb(input int p, input int id, input logic [63:0] res,
                        input logic ex, input logic [63:0] cause);
    wb_valid[p]            = 1'b1;
    wb_trans_id[p*TB +: TB] = TB'(id);
    wb_result[p*DW +: DW]  = res;
    wb_ex_valid[p]         = ex;
    wb_ex_cause[p*64 +: 64] = cause;
  endtask

  task automatic issue_n(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      issue_valid = 1'b1;
      issue_pc    = base + 64'(i);
      issue_rd    = 5'(i + 1);
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_cnt;
    int issued;
    int committed;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_ready", issue_ready, 1);
    check("rst_tid", issue_trans_id, 0);
    check("rst_cvalid", commit_valid, 0);
    check("rst_cresult", commit_result, 0);
    check("rst_cpc", commit_pc, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);

    // Fill without write-back
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1;
      issue_pc    = 64'h100 + 64'(i);
      issue_rd    = 5'(i);
      #1;
      check($sformatf("fill_tid%0d", i), issue_trans_id, i);
      cyc();
    end
    check("fill_full", full, 1);
    check("fill_ready", issue_ready, 0);
    check("fill_count", count, 4);
    check("fill_cvalid", commit_valid, 0);
    issue_valid = 1'b1;
    #1;
    cyc();
    check("fifth_count", count, 4);
    check("fifth_full", full, 1);
    flush = 1'b1;
    cyc();
    check("flush1_empty", empty, 1);

    // Out-of-order write-back, in-order commit
    issue_n(3, 64'h200);
    commit_ack = 1'b1; set_wb(2, 2, 64'hC, 1'b0, 0);
    #1;
    check("ooo_c1_valid", commit_valid, 0);
    cyc();
    commit_ack = 1'b1; set_wb(0, 0, 64'hA, 1'b0, 0);
    #1;
    check("ooo_c2_valid", commit_valid, 0);
    cyc();
    commit_ack = 1'b1; set_wb(1, 1, 64'hB, 1'b0, 0);
    #1;
    check("ooo_c3_valid", commit_valid, 1);
    check("ooo_c3_result", commit_result, 64'hA);
    check("ooo_c3_tid", commit_trans_id, 0);
    check("ooo_c3_pc", commit_pc, 64'h200);
    check("ooo_c3_rd", commit_rd, 1);
    cyc();
    commit_ack = 1'b1;
    #1;
    check("ooo_c4_valid", commit_valid, 1);
    check("ooo_c4_result", commit_result, 64'hB);
    check("ooo_c4_tid", commit_trans_id, 1);
    cyc();
    commit_ack = 1'b1;
    #1;
    check("ooo_c5_valid", commit_valid, 1);
    check("ooo_c5_result", commit_result, 64'hC);
    check("ooo_c5_tid", commit_trans_id, 2);
    cyc();
    check("ooo_empty", empty, 1);
    check("ooo_cvalid", commit_valid, 0);
    check("ooo_cresult", commit_result, 0);

    // Same-ID conflict plus exception
    flush = 1'b1;
    cyc();
    issue_n(2, 64'h300);
    set_wb(0, 1, 64'h11, 1'b0, 0);
    set_wb(3, 1, 64'h33, 1'b0, 0);
    set_wb(1, 0, 64'h7, 1'b1, 64'd13);
    cyc();
    check("ex_valid", commit_valid, 1);
    check("ex_tid", commit_trans_id, 0);
    check("ex_result", commit_result, 64'h7);
    check("ex_flag", commit_ex_valid, 1);
    check("ex_cause", commit_ex_cause, 64'd13);
    commit_ack = 1'b1;
    cyc();
    check("conf_tid", commit_trans_id, 1);
    check("conf_result", commit_result, 64'h11);
    check("conf_exflag", commit_ex_valid, 0);
    check("conf_cause", commit_ex_cause, 0);
    commit_ack = 1'b1;
    cyc();
    check("conf_empty", empty, 1);

    // Wrap-around: pointers start at 2, ten back-to-back transactions
    for (int i = 0; i <= 12; i++) begin
      if (i < 10) begin
        issue_valid = 1'b1;
        issue_pc    = 64'h1000 + 64'(i);
        issue_rd    = 5'(i);
      end
      if (i >= 1 && i <= 10) set_wb(i % NP, (2 + i - 1) % NE, 64'h100 + 64'(i - 1), 1'b0, 0);
      commit_ack = 1'b1;
      #1;
      issued    = (i < 10) ? i : 10;
      committed = (i < 2) ? 0 : ((i - 2 > 10) ? 10 : i - 2);
      exp_cnt   = issued - committed;
      if (i < 10) check($sformatf("wrap_tid%0d", i), issue_trans_id, (2 + i) % NE);
      check($sformatf("wrap_count%0d", i), count, exp_cnt);
      check($sformatf("wrap_valid%0d", i), commit_valid, (i >= 2 && i <= 11) ? 1 : 0);
      if (i >= 2 && i <= 11) begin
        check($sformatf("wrap_result%0d", i), commit_result, 64'h100 + 64'(i - 2));
        check($sformatf("wrap_ctid%0d", i), commit_trans_id, i % NE);
        check($sformatf("wrap_cpc%0d", i), commit_pc, 64'h1000 + 64'(i - 2));
      end
      cyc();
    end
    check("wrap_empty", empty, 1);

    // Flush while a write-back and an issue arrive in the same cycle
    issue_n(3, 64'h400);
    check("pre_flush_count", count, 3);
    flush = 1'b1; issue_valid = 1'b1; issue_pc = 64'h999; commit_ack = 1'b1;
    set_wb(0, 1, 64'h55, 1'b0, 0);
    cyc();
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_cvalid", commit_valid, 0);
    check("fl_tid", issue_trans_id, 0);
    check("fl_ready", issue_ready, 1);
    set_wb(0, 1, 64'h99, 1'b0, 0);
    commit_ack = 1'b1;
    cyc();
    check("fl_late_cvalid", commit_valid, 0);
    check("fl_late_count", count, 0);
    check("fl_late_result", commit_result, 0);
    issue_valid = 1'b1; issue_pc = 64'h500; issue_rd = 5'd9;
    #1;
    check("post_fl_tid", issue_trans_id, 0);
    cyc();
    check("post_fl_count", count, 1);
    check("post_fl_cvalid", commit_valid, 0);
    check("post_fl_pc", commit_pc, 64'h500);
    check("post_fl_rd", commit_rd, 9);
    check("post_fl_result", commit_result, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
